mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one single-port, synchronous-read memory between the core's instruction-fetch port and its load/store port. It sits between the core and a unified instruction/data RAM. It issues at most one memory access per cycle, arbitrates round-robin when both ports request, and routes each read response back to the port that issued it. It also keeps a saturating count of contention cycles for performance analysis.

## Interface
- ADDR_WIDTH, 12, memory address width in bits (byte address)
- DATA_WIDTH, 32, data width; must be 32 (byte enables are 4 bits)

- clk_i  in  1  clock; all state updates on the rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held until granted
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch accepted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_WIDTH  fetch data
- dm_req_i  in  1  load/store request; held until granted
- dm_addr_i  in  ADDR_WIDTH  load/store address
- dm_we_i  in  4  byte write enables; 0 means load
- dm_wdata_i  in  DATA_WIDTH  store data
- dm_gnt_o  out  1  load/store accepted this cycle
- dm_rvalid_o  out  1  load data valid, or store acknowledge
- dm_rdata_o  out  DATA_WIDTH  load data
- mem_en_o  out  1  memory access this cycle
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  4  memory byte write enables
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid the cycle after mem_en_o
- conflict_cnt_o  out  16  saturating count of cycles with both requests high

## Operation
- Handshake: a transfer occurs on a rising edge when req and gnt are both high. The requester holds req, addr, we and wdata stable until gnt is seen. The requester may drop req before gnt is seen.
- Grant (combinational):
  - One requester: it is granted.
  - Both requesters: the port not granted most recently wins.
  - No requester: no grant.
  - if_gnt_o and dm_gnt_o are never both high.
- last_q: a one-bit register recording the last granted port (0 = IF, 1 = DM). It updates only on a grant. Reset value is 1, so IF wins the first contention.
- Memory drive:
  - mem_en_o = if_gnt_o | dm_gnt_o.
  - mem_addr_o and mem_wdata_o come from the granted port.
  - mem_we_o = dm_we_i when DM is granted, otherwise 0. IF never writes.
  - With no grant, mem_addr_o, mem_we_o and mem_wdata_o are 0.
- Response:
  - Registers own_q (port granted) and pend_q (a grant occurred) are captured at each edge.
  - The cycle after a grant, the owner's rvalid goes high. Its rdata = mem_rdata_i.
  - For a DM store, dm_rvalid_o is still asserted as the acknowledge, and dm_rdata_o is the memory output.
  - The non-owner's rdata is 0. rvalid stays low with no pending response.
- conflict_cnt_o: increments on each edge where if_req_i & dm_req_i are both high. It holds at 16'hFFFF.

## Timing
- Grant latency: 0 cycles (same cycle as req).
- Read data latency: 1 cycle after the grant edge.
- Throughput: one access per cycle. A new grant and the previous response may occur in the same cycle.
- Reset (rstn_i low, asynchronous):
  - last_q = 1, pend_q = 0, own_q = 0, conflict_cnt_o = 0.
  - Grants and mem_en_o are forced 0 while reset is asserted. All outputs are 0.
- Reset mid-operation: a pending response is discarded, and no rvalid follows reset release. Requesters re-issue.
- Simultaneous events:
  - A port may be granted in the cycle its previous response returns.
  - Under continuous contention, grants strictly alternate.
- A request withdrawn before its grant leaves no state, except the conflict count for cycles already counted.

## Test plan
- Reset: hold rstn_i low with both reqs high. Required: all gnt, rvalid and mem_en_o = 0, conflict_cnt_o = 0. After release, the first contention grants IF.
- Fetch alone: if_req_i = 1, if_addr_i = 0x010, memory word 0x00500093. Required: if_gnt_o = 1 and mem_addr_o = 0x010 in the same cycle. Next cycle: if_rvalid_o = 1, if_rdata_o = 0x00500093, dm_rdata_o = 0.
- Store alone: dm_we_i = 4'b0011, dm_addr_i = 0x020, dm_wdata_i = 0xDEADBEEF. Required: mem_we_o = 4'b0011 and mem_wdata_o = 0xDEADBEEF. Next cycle: dm_rvalid_o = 1. A subsequent load from 0x020 returns low half 0xBEEF.
- Contention: both reqs held for 4 cycles after reset. Required grant order IF, DM, IF, DM, with responses to the matching ports one cycle later. conflict_cnt_o = 4.
- Reset mid-transfer: assert rstn_i the cycle after a DM grant. Required: dm_rvalid_o stays 0 through reset and after release.
- Saturation: force 65537 contention cycles. Required: conflict_cnt_o = 0xFFFF and it holds.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IF/DM arbiter for one single-port synchronous-read RAM
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  dm_req_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [3:0]            dm_we_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [15:0]           conflict_cnt_o
);

    logic        r_last;
    logic        r_pend;
    logic        r_own;
    logic [15:0] r_conflict_cnt;

    logic w_if_gnt;
    logic w_dm_gnt;
    logic w_any_gnt;
    logic w_both_req;
    logic w_if_resp;
    logic w_dm_resp;

    // r_last = 1 means DM was granted last, so IF wins the next contention.
    assign w_both_req = if_req_i & dm_req_i;
    assign w_if_gnt   = rstn_i & if_req_i & (~dm_req_i | r_last);
    assign w_dm_gnt   = rstn_i & dm_req_i & (~if_req_i | ~r_last);
    assign w_any_gnt  = w_if_gnt | w_dm_gnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last         <= 1'b1;
            r_pend         <= 1'b0;
            r_own          <= 1'b0;
            r_conflict_cnt <= 16'h0000;
        end else begin
            if (w_any_gnt) begin
                r_last <= w_dm_gnt;
            end
            r_pend <= w_any_gnt;
            r_own  <= w_dm_gnt;
            if (w_both_req && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign if_gnt_o = w_if_gnt;
    assign dm_gnt_o = w_dm_gnt;

    assign mem_en_o    = w_any_gnt;
    assign mem_addr_o  = w_dm_gnt ? dm_addr_i : (w_if_gnt ? if_addr_i : '0);
    assign mem_we_o    = w_dm_gnt ? dm_we_i : 4'b0000;
    assign mem_wdata_o = w_dm_gnt ? dm_wdata_i : '0;

    // Stores are acknowledged through dm_rvalid_o just like loads.
    assign w_if_resp   = r_pend & ~r_own;
    assign w_dm_resp   = r_pend & r_own;
    assign if_rvalid_o = w_if_resp;
    assign dm_rvalid_o = w_dm_resp;
    assign if_rdata_o  = w_if_resp ? mem_rdata_i : '0;
    assign dm_rdata_o  = w_dm_resp ? mem_rdata_i : '0;

    assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [11:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0;
    logic [11:0] dm_addr_i = '0;
    logic [3:0]  dm_we_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic        dm_gnt_o, dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_en_o;
    logic [11:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic [15:0] conflict_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_we_i(dm_we_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk = ~clk;

    // Bench RAM: read-first, byte-enabled; loaded from ref_mem on the first edge.
    logic [31:0] tb_mem  [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= ref_mem[i];
            mem_loaded <= 1'b1;
        end else if (mem_en_o) begin
            mem_rdata_i <= tb_mem[mem_addr_o[11:2]];
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) tb_mem[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    // Reference model: port identities as ints (-1 none, 0 IF, 1 DM).
    int          m_last, m_pend, m_cnt, e_g;
    logic [31:0] m_data;
    logic        m_gnt_if, m_gnt_dm;
    logic [11:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
    logic [15:0] e_cnt;

    task automatic model_reset();
        m_last = 1; m_pend = -1; m_cnt = 0; m_gnt_if = 1'b0; m_gnt_dm = 1'b0;
    endtask

    task automatic predict();
        e_g = -1;
        if (rstn_i) begin
            if (if_req_i && dm_req_i) e_g = (m_last == 1) ? 0 : 1;
            else if (if_req_i) e_g = 0;
            else if (dm_req_i) e_g = 1;
        end
        e_addr  = (e_g == 0) ? if_addr_i : (e_g == 1) ? dm_addr_i : 12'h000;
        e_we    = (e_g == 1) ? dm_we_i : 4'h0;
        e_wdata = (e_g == 1) ? dm_wdata_i : 32'h0;
        e_cnt   = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    endtask

    task automatic model_edge();
        int w;
        predict();
        m_gnt_if = (e_g == 0);
        m_gnt_dm = (e_g == 1);
        if (rstn_i) begin
            if (if_req_i && dm_req_i) m_cnt++;
            if (e_g >= 0) begin
                w = int'(e_addr[11:2]);
                m_data = ref_mem[w];
                m_pend = e_g;
                m_last = e_g;
                if (e_g == 1)
                    for (int b = 0; b < 4; b++)
                        if (dm_we_i[b]) ref_mem[w][8*b +: 8] = dm_wdata_i[8*b +: 8];
            end else begin
                m_pend = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_addr_i = '0; dm_we_i = '0; dm_wdata_i = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rstn_i = 1'b0;
        drive_idle();
        model_reset();
        @(posedge clk);
        #1 rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        if_req_i = 1'b1; if_addr_i = 12'h040;
        dm_req_i = 1'b1; dm_addr_i = 12'h080;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_en_o} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b required 00000", {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_en_o});
        end
        n_checks++;
        if (conflict_cnt_o !== 16'h0 || mem_addr_o !== 12'h0 || mem_we_o !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_data: got cnt=%h addr=%h we=%h required 0", conflict_cnt_o, mem_addr_o, mem_we_o);
        end
        @(posedge clk);
        #1 rstn_i = 1'b1;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({if_gnt_o, dm_gnt_o} !== 2'b10) begin
            n_errors++;
            $display("FAIL reset_first_contention: got if/dm gnt %b required 10", {if_gnt_o, dm_gnt_o});
        end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_fetch();
        if_req_i = 1'b1; if_addr_i = 12'h010;
        @(negedge clk);
        n_checks++;
        if (if_gnt_o !== 1'b1 || dm_gnt_o !== 1'b0 || mem_addr_o !== 12'h010) begin
            n_errors++;
            $display("FAIL fetch_grant: got gnt=%b/%b addr=%h required 1/0 010", if_gnt_o, dm_gnt_o, mem_addr_o);
        end
        tick();
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h00500093 || dm_rdata_o !== 32'h0 || dm_rvalid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_resp: got rv=%b data=%h dm_rv=%b dm_data=%h required 1 00500093 0 0",
                     if_rvalid_o, if_rdata_o, dm_rvalid_o, dm_rdata_o);
        end
        tick();
    endtask

    task automatic test_store_load();
        dm_req_i = 1'b1; dm_addr_i = 12'h020; dm_we_i = 4'b0011; dm_wdata_i = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if (dm_gnt_o !== 1'b1 || mem_we_o !== 4'b0011 || mem_wdata_o !== 32'hDEADBEEF || mem_addr_o !== 12'h020) begin
            n_errors++;
            $display("FAIL store_drive: got gnt=%b we=%b wdata=%h addr=%h required 1 0011 deadbeef 020",
                     dm_gnt_o, mem_we_o, mem_wdata_o, mem_addr_o);
        end
        tick();
        dm_we_i = 4'b0000; dm_wdata_i = 32'h0;
        @(negedge clk);
        n_checks++;
        if (dm_rvalid_o !== 1'b1 || dm_gnt_o !== 1'b1 || mem_we_o !== 4'b0000) begin
            n_errors++;
            $display("FAIL store_ack_b2b: got rv=%b gnt=%b we=%b required 1 1 0000", dm_rvalid_o, dm_gnt_o, mem_we_o);
        end
        tick();
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== 32'h1234BEEF || if_rvalid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL load_after_store: got rv=%b data=%h if_rv=%b required 1 1234beef 0",
                     dm_rvalid_o, dm_rdata_o, if_rvalid_o);
        end
        tick();
    endtask

    task automatic test_contention();
        reset_pulse();
        if_req_i = 1'b1; if_addr_i = 12'h100;
        dm_req_i = 1'b1; dm_addr_i = 12'h204;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({if_gnt_o, dm_gnt_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_errors++;
                $display("FAIL contention_grant[%0d]: got if/dm %b", k, {if_gnt_o, dm_gnt_o});
            end
            if (k > 0) begin
                n_checks++;
                if ((k % 2 == 1) ? (if_rvalid_o !== 1'b1 || dm_rvalid_o !== 1'b0 || if_rdata_o !== ref_mem[64])
                                 : (dm_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0 || dm_rdata_o !== ref_mem[129])) begin
                    n_errors++;
                    $display("FAIL contention_resp[%0d]: got if_rv=%b dm_rv=%b if_data=%h dm_data=%h required port %0d",
                             k, if_rvalid_o, dm_rvalid_o, if_rdata_o, dm_rdata_o, (k - 1) % 2);
                end
            end
            tick();
        end
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== ref_mem[129] || conflict_cnt_o !== 16'd4) begin
            n_errors++;
            $display("FAIL contention_tail: got dm_rv=%b data=%h cnt=%0d required 1 %h 4",
                     dm_rvalid_o, dm_rdata_o, conflict_cnt_o, ref_mem[129]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        dm_req_i = 1'b1; dm_addr_i = 12'h030;
        @(negedge clk);
        n_checks++;
        if (dm_gnt_o !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_grant: got %b required 1", dm_gnt_o);
        end
        @(posedge clk);
        #1 rstn_i = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk);
        n_checks++;
        if (dm_rvalid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_during: got dm_rvalid %b required 0", dm_rvalid_o);
        end
        @(posedge clk);
        #1 rstn_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (dm_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL midreset_after[%0d]: got dm/if rvalid %b%b required 00", k, dm_rvalid_o, if_rvalid_o);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [132:0] got, exp;
        for (int c = 0; c < 3000; c++) begin
            if (!(if_req_i && !m_gnt_if && $urandom_range(0, 7) != 0)) begin
                if_req_i  = 1'($urandom_range(0, 1));
                if_addr_i = {10'($urandom_range(0, 1023)), 2'b00};
            end
            if (!(dm_req_i && !m_gnt_dm && $urandom_range(0, 7) != 0)) begin
                dm_req_i   = 1'($urandom_range(0, 1));
                dm_addr_i  = {10'($urandom_range(0, 63)), 2'b00};
                dm_we_i    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                dm_wdata_i = $urandom;
            end
            @(negedge clk);
            predict();
            got = {if_gnt_o, dm_gnt_o, mem_en_o, mem_addr_o, mem_we_o, mem_wdata_o,
                   if_rvalid_o, if_rdata_o, dm_rvalid_o, dm_rdata_o, conflict_cnt_o};
            exp = {e_g == 0, e_g == 1, e_g >= 0, e_addr, e_we, e_wdata,
                   m_pend == 0, (m_pend == 0) ? m_data : 32'h0,
                   m_pend == 1, (m_pend == 1) ? m_data : 32'h0, e_cnt};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random[%0d]: got %h required %h", c, got, exp);
            end
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_saturation();
        reset_pulse();
        if_req_i = 1'b1; if_addr_i = 12'h008;
        dm_req_i = 1'b1; dm_addr_i = 12'h00C;
        repeat (65534) tick();
        @(negedge clk);
        n_checks++;
        if (conflict_cnt_o !== 16'hFFFE) begin
            n_errors++;
            $display("FAIL sat_below: got %h required fffe", conflict_cnt_o);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (conflict_cnt_o !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL sat_reach: got %h required ffff", conflict_cnt_o);
        end
        repeat (2) tick();
        @(negedge clk);
        n_checks++;
        if (conflict_cnt_o !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL sat_hold: got %h required ffff", conflict_cnt_o);
        end
        drive_idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'h00500093;
        ref_mem[8] = 32'h12345678;
        model_reset();
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
